if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. It handles stalls from hazard detection, redirects (branch/jump) from later stages, and halt detection. It also keeps a fetched-instruction counter.

---
 rtl/if_fetch_stage_if.sv | 16 +
 rtl/if_fetch_stage.sv | 84 ++++++++
 tb/tb_if_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a
// zero-latency (combinational) instruction memory.
interface if_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC, IF/ID register, stall/redirect/halt
// handling and a saturating fetched-instruction counter.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  if_fetch_stage_if.master   imem,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               halted,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        is_halt;
  logic        cnt_full;

  assign imem.imem_addr = pc;
  assign pc_plus4       = pc + 32'd4;
  assign is_halt        = (imem.imem_data == HALT_INSTR);
  assign cnt_full       = &fetch_count;
  assign halted         = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
      misalign_err   <= 1'b0;
      fetch_count    <= '0;
    end else begin
      misalign_err <= 1'b0;
      priority case (1'b1)
        redirect: begin
          // A redirect also cancels a speculatively fetched HALT.
          state          <= RUN;
          pc             <= {redirect_target[31:2], 2'b00};
          if_id_instr    <= NOP_INSTR;
          if_id_pc_plus4 <= 32'd0;
          if_id_valid    <= 1'b0;
          misalign_err   <= |redirect_target[1:0];
        end
        stall: begin
        end
        (state == HALT): begin
          if_id_instr    <= NOP_INSTR;
          if_id_pc_plus4 <= 32'd0;
          if_id_valid    <= 1'b0;
        end
        default: begin
          if_id_instr    <= imem.imem_data;
          if_id_pc_plus4 <= pc_plus4;
          if_id_valid    <= 1'b1;
          if (!cnt_full)
            fetch_count <= fetch_count + COUNT_W'(1);
          // HALT is passed downstream, but PC parks on it.
          if (is_halt)
            state <= HALT;
          else
            pc <= pc_plus4;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: per-cycle expected
// outputs queued with their stimulus, popped after each edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] tgt = 32'd0;
  logic [31:0] instr, pc4;
  logic        valid, halted, mis;
  logic [31:0] cnt;

  logic        rst4 = 1'b1;
  logic        stall4 = 1'b0;
  logic        redir4 = 1'b0;
  logic [31:0] tgt4 = 32'd0;
  logic [31:0] instr4, pc44;
  logic        valid4, halted4, mis4;
  logic [3:0]  cnt4;

  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if bus ();
  if_fetch_stage_if bus4 ();

  assign bus.imem_data  = mem[bus.imem_addr[7:2]];
  assign bus4.imem_data = 32'h1234_5678;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (tgt),
    .imem            (bus),
    .if_id_instr     (instr),
    .if_id_pc_plus4  (pc4),
    .if_id_valid     (valid),
    .halted          (halted),
    .misalign_err    (mis),
    .fetch_count     (cnt)
  );

  if_fetch_stage #(.COUNT_W(4)) dut4 (
    .clk             (clk),
    .rst             (rst4),
    .stall           (stall4),
    .redirect        (redir4),
    .redirect_target (tgt4),
    .imem            (bus4),
    .if_id_instr     (instr4),
    .if_id_pc_plus4  (pc44),
    .if_id_valid     (valid4),
    .halted          (halted4),
    .misalign_err    (mis4),
    .fetch_count     (cnt4)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [130:0] exp;
  } vec_t;

  vec_t sb[$];

  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h2009_0003;
  localparam logic [31:0] W2 = 32'h0109_5020;
  localparam logic [31:0] W3 = 32'h8D0B_0000;
  localparam logic [31:0] WH = 32'hFFFF_FFFF;
  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WZ = 32'h0BAD_F00D;

  function automatic vec_t mk(
    input logic r, input logic s, input logic d,
    input logic [31:0] t, input logic [31:0] a,
    input logic [31:0] i, input logic [31:0] p,
    input logic v, input logic h, input logic m,
    input logic [31:0] c);
    vec_t x;
    x.rst   = r;
    x.stall = s;
    x.redir = d;
    x.tgt   = t;
    x.exp   = {a, i, p, v, h, m, c};
    return x;
  endfunction

  function automatic vec_t run_(
    input logic [31:0] a, input logic [31:0] i,
    input logic [31:0] p, input logic [31:0] c);
    return mk(0, 0, 0, 0, a, i, p, 1, 0, 0, c);
  endfunction

  task automatic test_reset();
    vec_t v;
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst = v.rst; stall = v.stall;
      redirect = v.redir; tgt = v.tgt;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.imem_addr, instr, pc4, valid, halted, mis, cnt}
          !== v.exp) begin
        n_bad++;
        $display("FAIL reset got %h exp %h",
          {bus.imem_addr, instr, pc4, valid, halted, mis, cnt}, v.exp);
      end
    end
  endtask

  task automatic test_fetch();
    vec_t v;
    int k = 0;
    sb.push_back(run_(4, W0, 4, 1));
    sb.push_back(run_(8, W1, 8, 2));
    sb.push_back(run_(12, W2, 12, 3));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst = v.rst; stall = v.stall;
      redirect = v.redir; tgt = v.tgt;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.imem_addr, instr, pc4, valid, halted, mis, cnt}
          !== v.exp) begin
        n_bad++;
        $display("FAIL fetch[%0d] got %h exp %h", k,
          {bus.imem_addr, instr, pc4, valid, halted, mis, cnt}, v.exp);
      end
      k++;
    end
  endtask

  task automatic test_stall();
    vec_t v;
    int k = 0;
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(run_(4, W0, 4, 1));
    sb.push_back(run_(8, W1, 8, 2));
    sb.push_back(mk(0, 1, 0, 0, 8, W1, 8, 1, 0, 0, 2));
    sb.push_back(mk(0, 1, 0, 0, 8, W1, 8, 1, 0, 0, 2));
    sb.push_back(run_(12, W2, 12, 3));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst = v.rst; stall = v.stall;
      redirect = v.redir; tgt = v.tgt;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.imem_addr, instr, pc4, valid, halted, mis, cnt}
          !== v.exp) begin
        n_bad++;
        $display("FAIL stall[%0d] got %h exp %h", k,
          {bus.imem_addr, instr, pc4, valid, halted, mis, cnt}, v.exp);
      end
      k++;
    end
  endtask

  task automatic test_redirect();
    vec_t v;
    int k = 0;
    sb.push_back(mk(0, 1, 1, 32'h40, 32'h40, 0, 0, 0, 0, 0, 3));
    sb.push_back(run_(32'h44, WA, 32'h44, 4));
    sb.push_back(mk(0, 0, 1, 32'h42, 32'h40, 0, 0, 0, 0, 1, 4));
    sb.push_back(run_(32'h44, WA, 32'h44, 5));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst = v.rst; stall = v.stall;
      redirect = v.redir; tgt = v.tgt;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.imem_addr, instr, pc4, valid, halted, mis, cnt}
          !== v.exp) begin
        n_bad++;
        $display("FAIL redirect[%0d] got %h exp %h", k,
          {bus.imem_addr, instr, pc4, valid, halted, mis, cnt}, v.exp);
      end
      k++;
    end
  endtask

  task automatic test_halt();
    vec_t v;
    int k = 0;
    sb.push_back(mk(0, 0, 1, 32'h0C, 32'h0C, 0, 0, 0, 0, 0, 5));
    sb.push_back(run_(32'h10, W3, 32'h10, 6));
    sb.push_back(mk(0, 1, 0, 0, 32'h10, W3, 32'h10, 1, 0, 0, 6));
    sb.push_back(mk(0, 0, 0, 0, 32'h10, WH, 32'h14, 1, 1, 0, 7));
    sb.push_back(mk(0, 0, 0, 0, 32'h10, 0, 0, 0, 1, 0, 7));
    sb.push_back(mk(0, 1, 0, 0, 32'h10, 0, 0, 0, 1, 0, 7));
    sb.push_back(mk(0, 0, 0, 0, 32'h10, 0, 0, 0, 1, 0, 7));
    sb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7));
    sb.push_back(run_(4, W0, 4, 8));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst = v.rst; stall = v.stall;
      redirect = v.redir; tgt = v.tgt;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.imem_addr, instr, pc4, valid, halted, mis, cnt}
          !== v.exp) begin
        n_bad++;
        $display("FAIL halt[%0d] got %h exp %h", k,
          {bus.imem_addr, instr, pc4, valid, halted, mis, cnt}, v.exp);
      end
      k++;
    end
  endtask

  task automatic test_wrap_and_reset();
    vec_t v;
    int k = 0;
    sb.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                    0, 0, 0, 0, 0, 8));
    sb.push_back(run_(0, WZ, 0, 9));
    sb.push_back(run_(4, W0, 4, 10));
    sb.push_back(mk(1, 1, 1, 32'h42, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(run_(4, W0, 4, 1));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst = v.rst; stall = v.stall;
      redirect = v.redir; tgt = v.tgt;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.imem_addr, instr, pc4, valid, halted, mis, cnt}
          !== v.exp) begin
        n_bad++;
        $display("FAIL wrap_rst[%0d] got %h exp %h", k,
          {bus.imem_addr, instr, pc4, valid, halted, mis, cnt}, v.exp);
      end
      k++;
    end
  endtask

  task automatic test_saturate();
    logic [67:0] q[$];
    logic [67:0] e;
    logic [31:0] p;
    logic [3:0]  c;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      p = 32'(4 * i);
      c = (i > 15) ? 4'hF : 4'(i);
      q.push_back({p, 32'h1234_5678, c});
    end
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_cmp++;
      if ({bus4.imem_addr, instr4, cnt4} !== e || !valid4) begin
        n_bad++;
        $display("FAIL sat[%0d] got %h v%b exp %h v1", i,
          {bus4.imem_addr, instr4, cnt4}, valid4, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0]  = W0;
    mem[1]  = W1;
    mem[2]  = W2;
    mem[3]  = W3;
    mem[4]  = WH;
    mem[16] = WA;
    mem[63] = WZ;
    @(posedge clk); #1;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_and_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
